// File: rtl/keyvalue_cam.sv
// keyvalue_cam: key/value CAM with lookup, reverse lookup, insert and delete over a bus handshake
module keyvalue_cam #(
  parameter int KEY_W = 16,
  parameter int VAL_W = 16,
  parameter int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             CYC_i,
  input  logic             STB_i,
  input  logic [1:0]       OP_i,
  input  logic [KEY_W-1:0] KEY_i,
  input  logic [VAL_W-1:0] VAL_i,
  output logic             ACK_o,
  output logic             STALL_o,
  output logic             HIT_o,
  output logic             DUP_o,
  output logic             ERR_o,
  output logic [KEY_W-1:0] KEY_o,
  output logic [VAL_W-1:0] VAL_o,
  output logic [IDX_W-1:0] IDX_o,
  output logic [IDX_W:0]   COUNT_o,
  output logic             FULL_o
);
  localparam int CW = IDX_W + 1;
  localparam logic [1:0] OP_LOOKUP = 2'b00, OP_RLOOKUP = 2'b01, OP_INSERT = 2'b10, OP_DELETE = 2'b11;
  typedef enum logic [1:0] {IDLE, SEARCH, EXEC} state_t;
  state_t state;
  logic [DEPTH-1:0] valid;
  logic [KEY_W-1:0] keys [DEPTH];
  logic [VAL_W-1:0] vals [DEPTH];
  logic [1:0]       op_q;
  logic [KEY_W-1:0] key_q;
  logic [VAL_W-1:0] val_q;
  logic [IDX_W-1:0] m_idx, f_idx, s_idx, s_free;
  logic [1:0]       m_cnt, s_cnt;
  logic             f_found, hit_i, s_hit;
  assign FULL_o = COUNT_o == CW'(DEPTH);
  assign s_hit = s_cnt != 2'd0;
  // parallel compare: lowest match, saturating match count, lowest free slot
  always_comb begin
    m_idx = '0;
    m_cnt = '0;
    f_idx = '0;
    f_found = 1'b0;
    hit_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_i = valid[i] && (op_q == OP_RLOOKUP ? vals[i] == val_q : keys[i] == key_q);
      m_idx = (hit_i && m_cnt == 2'd0) ? IDX_W'(i) : m_idx;
      m_cnt = (hit_i && m_cnt != 2'd2) ? m_cnt + 2'd1 : m_cnt;
      f_idx = (!valid[i] && !f_found) ? IDX_W'(i) : f_idx;
      f_found = f_found || !valid[i];
    end
  end
  // request FSM, storage updates and registered results; ACK follows EXEC by one cycle
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        keys[i] <= '0;
        vals[i] <= '0;
      end
      op_q <= '0;
      key_q <= '0;
      val_q <= '0;
      s_idx <= '0;
      s_cnt <= '0;
      s_free <= '0;
      ACK_o <= 1'b0;
      STALL_o <= 1'b0;
      HIT_o <= 1'b0;
      DUP_o <= 1'b0;
      ERR_o <= 1'b0;
      KEY_o <= '0;
      VAL_o <= '0;
      IDX_o <= '0;
      COUNT_o <= '0;
    end else begin
      ACK_o <= 1'b0;
      case (state)
        IDLE: if (CYC_i && STB_i && !ACK_o) begin
          op_q <= OP_i;
          key_q <= KEY_i;
          val_q <= VAL_i;
          state <= SEARCH;
          STALL_o <= 1'b1;
        end
        SEARCH: begin
          s_idx <= m_idx;
          s_cnt <= m_cnt;
          s_free <= f_idx;
          state <= CYC_i ? EXEC : IDLE;
          STALL_o <= CYC_i;
        end
        EXEC: begin
          state <= IDLE;
          STALL_o <= 1'b0;
          if (CYC_i) begin
            ACK_o <= 1'b1;
            HIT_o <= s_hit;
            DUP_o <= (op_q == OP_INSERT && s_hit) || (op_q == OP_RLOOKUP && s_cnt == 2'd2);
            ERR_o <= op_q == OP_INSERT && !s_hit && FULL_o;
            KEY_o <= op_q == OP_RLOOKUP ? (s_hit ? keys[s_idx] : '0) : key_q;
            VAL_o <= op_q == OP_INSERT ? val_q : op_q == OP_RLOOKUP ? (s_hit ? val_q : '0) : (s_hit ? vals[s_idx] : '0);
            IDX_o <= s_hit ? s_idx : (op_q == OP_INSERT && !FULL_o) ? s_free : '0;
            if (op_q == OP_INSERT && s_hit) vals[s_idx] <= val_q;
            if (op_q == OP_INSERT && !s_hit && !FULL_o) begin
              valid[s_free] <= 1'b1;
              keys[s_free] <= key_q;
              vals[s_free] <= val_q;
              COUNT_o <= COUNT_o + CW'(1);
            end
            if (op_q == OP_DELETE && s_hit) begin
              valid[s_idx] <= 1'b0;
              COUNT_o <= COUNT_o - CW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          STALL_o <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_keyvalue_cam.sv
// tb_keyvalue_cam: randomized and directed checking of keyvalue_cam against a table model
module tb_keyvalue_cam;
  localparam int D = 8;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        CYC_i = 1'b0, STB_i = 1'b0;
  logic [1:0]  OP_i = '0;
  logic [15:0] KEY_i = '0, VAL_i = '0;
  logic        ACK_o, STALL_o, HIT_o, DUP_o, ERR_o, FULL_o;
  logic [15:0] KEY_o, VAL_o;
  logic [2:0]  IDX_o;
  logic [3:0]  COUNT_o;
  int checks = 0, errors = 0;
  bit          m_valid [D];
  logic [15:0] m_key [D], m_val [D];
  int          m_count = 0;

  keyvalue_cam dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .CYC_i(CYC_i), .STB_i(STB_i), .OP_i(OP_i),
    .KEY_i(KEY_i), .VAL_i(VAL_i), .ACK_o(ACK_o), .STALL_o(STALL_o), .HIT_o(HIT_o),
    .DUP_o(DUP_o), .ERR_o(ERR_o), .KEY_o(KEY_o), .VAL_o(VAL_o), .IDX_o(IDX_o),
    .COUNT_o(COUNT_o), .FULL_o(FULL_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < D; i++) begin
      m_valid[i] = 0;
      m_key[i] = '0;
      m_val[i] = '0;
    end
    m_count = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge sys_clk);
    while ((STALL_o || ACK_o) && n < 8) begin
      @(negedge sys_clk);
      n++;
    end
    check("idle_wait", 32'(n < 8), 1);
  endtask

  // one full transaction: model prediction, 3-cycle ACK timing and all result outputs
  task automatic xact(input logic [1:0] op, input logic [15:0] k, input logic [15:0] v);
    int mi, nm, fi;
    logic [15:0] ek, ev;
    int ei;
    bit eh, ed, ee;
    mi = -1; nm = 0; fi = -1;
    for (int i = 0; i < D; i++) begin
      if (m_valid[i] && (op == 2'b01 ? m_val[i] == v : m_key[i] == k)) begin
        if (mi < 0) mi = i;
        nm++;
      end
      if (!m_valid[i] && fi < 0) fi = i;
    end
    eh = mi >= 0; ed = 0; ee = 0; ek = k; ev = '0; ei = eh ? mi : 0;
    case (op)
      2'b00: if (eh) ev = m_val[mi];
      2'b01: begin
        if (eh) begin ek = m_key[mi]; ev = v; end else ek = '0;
        ed = nm > 1;
      end
      2'b10: begin
        ev = v; ed = eh;
        if (eh) m_val[mi] = v;
        else if (m_count < D) begin
          ei = fi; m_valid[fi] = 1; m_key[fi] = k; m_val[fi] = v; m_count++;
        end else ee = 1;
      end
      default: if (eh) begin
        ev = m_val[mi]; m_valid[mi] = 0; m_count--;
      end
    endcase
    wait_idle();
    CYC_i = 1; STB_i = 1; OP_i = op; KEY_i = k; VAL_i = v;
    @(posedge sys_clk); #1;
    STB_i = 0;
    check("stall_search", 32'(STALL_o), 1);
    check("ack_early1", 32'(ACK_o), 0);
    @(posedge sys_clk); #1;
    check("ack_early2", 32'(ACK_o), 0);
    @(posedge sys_clk); #1;
    check("ack", 32'(ACK_o), 1);
    check("stall_done", 32'(STALL_o), 0);
    check("hit", 32'(HIT_o), 32'(eh));
    check("dup", 32'(DUP_o), 32'(ed));
    check("err", 32'(ERR_o), 32'(ee));
    check("key", 32'(KEY_o), 32'(ek));
    check("val", 32'(VAL_o), 32'(ev));
    check("idx", 32'(IDX_o), 32'(ei));
    check("count", 32'(COUNT_o), 32'(m_count));
    check("full", 32'(FULL_o), 32'(m_count == D));
    @(negedge sys_clk);
    CYC_i = 0;
  endtask

  initial begin
    model_clear();
    sys_rst_n = 0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_ack", 32'(ACK_o), 0);
    check("rst_stall", 32'(STALL_o), 0);
    check("rst_flags", {29'b0, HIT_o, DUP_o, ERR_o}, 0);
    check("rst_outs", {KEY_o, VAL_o} | 32'(IDX_o), 0);
    check("rst_count", 32'(COUNT_o), 0);
    @(negedge sys_clk);
    sys_rst_n = 1;

    xact(2'b10, 16'h0011, 16'h00AA);
    xact(2'b00, 16'h0011, 16'h0000);
    check("lookup_val", 32'(VAL_o), 32'h00AA);
    xact(2'b10, 16'h0011, 16'h00BB);
    check("overwrite_dup", 32'(DUP_o), 1);
    xact(2'b00, 16'h0011, 16'h0000);
    check("overwrite_val", 32'(VAL_o), 32'h00BB);

    for (int i = 1; i < D; i++) xact(2'b10, 16'h0100 + 16'(i), 16'h1000 + 16'(i));
    xact(2'b10, 16'h0999, 16'h0001);
    check("full_err", 32'(ERR_o), 1);
    check("full_count", 32'(COUNT_o), 8);
    xact(2'b11, 16'h0103, 16'h0000);
    check("del_count", 32'(COUNT_o), 7);
    xact(2'b10, 16'h0777, 16'h0002);
    check("reuse_idx", 32'(IDX_o), 3);

    xact(2'b10, 16'h0102, 16'h0055);
    xact(2'b10, 16'h0105, 16'h0055);
    xact(2'b01, 16'h0000, 16'h0055);
    check("rlookup_idx", 32'(IDX_o), 2);
    check("rlookup_dup", 32'(DUP_o), 1);

    // no acceptance in the ACK cycle even with the strobe held
    wait_idle();
    CYC_i = 1; STB_i = 1; OP_i = 2'b00; KEY_i = 16'h0011; VAL_i = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("b2b_ack", 32'(ACK_o), 1);
    @(posedge sys_clk); #1;
    check("b2b_no_accept", 32'(STALL_o), 0);
    @(posedge sys_clk); #1;
    check("b2b_accept", 32'(STALL_o), 1);
    STB_i = 0;
    repeat (2) @(posedge sys_clk);
    #1;
    check("b2b_ack2", 32'(ACK_o), 1);
    @(negedge sys_clk);
    CYC_i = 0;

    xact(2'b11, 16'h0104, 16'h0000);
    wait_idle();
    CYC_i = 1; STB_i = 1; OP_i = 2'b10; KEY_i = 16'h4444; VAL_i = 16'h0044;
    @(posedge sys_clk); #1;
    STB_i = 0; CYC_i = 0;
    @(posedge sys_clk); #1;
    check("abort_ack1", 32'(ACK_o), 0);
    check("abort_stall", 32'(STALL_o), 0);
    @(posedge sys_clk); #1;
    check("abort_ack2", 32'(ACK_o), 0);
    check("abort_count", 32'(COUNT_o), 32'(m_count));
    xact(2'b00, 16'h4444, 16'h0000);

    wait_idle();
    CYC_i = 1; STB_i = 1; OP_i = 2'b11; KEY_i = 16'h0011; VAL_i = '0;
    @(posedge sys_clk); #1;
    STB_i = 0;
    @(posedge sys_clk); #1;
    sys_rst_n = 0;
    @(posedge sys_clk); #1;
    check("rstx_ack", 32'(ACK_o), 0);
    check("rstx_count", 32'(COUNT_o), 0);
    check("rstx_stall", 32'(STALL_o), 0);
    @(negedge sys_clk);
    sys_rst_n = 1; CYC_i = 0;
    model_clear();
    xact(2'b00, 16'h0011, 16'h0000);
    check("rstx_miss", 32'(HIT_o), 0);

    for (int n = 0; n < 250; n++)
      xact(2'($urandom_range(0, 3)), 16'h0020 + 16'($urandom_range(0, 11)), 16'h0011 * 16'($urandom_range(0, 3)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
